// File: rtl/lut_dump_pkg.sv
// Shared types and constants for the LUT dump sequencer.
package lut_dump_pkg;

    localparam int LATE_CNT_W = 16;
    localparam int PERIOD_W   = 32;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        FETCH,
        HOLD,
        WAIT,
        DONE
    } state_t;

    // Reads can never be spaced closer than one full read latency plus the hand-off cycle.
    function automatic logic [PERIOD_W-1:0] eff_period(input logic [PERIOD_W-1:0] period,
                                                       input int rd_lat);
        logic [PERIOD_W-1:0] floor_p;
        floor_p = PERIOD_W'(rd_lat + 1);
        return (period > floor_p) ? period : floor_p;
    endfunction

endpackage

// File: rtl/lut_dump_interval_ctr.sv
// Read-interval counter: reads 0 in the cycle restart_i is high, then counts up and saturates.
// elapsed_o flags that eff_period_i-1 cycles have passed since the restart cycle.
module lut_dump_interval_ctr
    import lut_dump_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                restart_i,
    input  logic [PERIOD_W-1:0] eff_period_i,
    output logic [PERIOD_W-1:0] cnt_o,
    output logic                elapsed_o
);

    logic [PERIOD_W-1:0] cnt_q;
    logic [PERIOD_W-1:0] cnt_d;

    assign cnt_o     = restart_i ? '0 : cnt_q;
    assign cnt_d     = (cnt_o == '1) ? cnt_o : cnt_o + PERIOD_W'(1);
    assign elapsed_o = (cnt_o >= eff_period_i - PERIOD_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/lut_dump_sequencer.sv
// Walks LUT addresses 0..last_addr at a programmable read period and streams the words out valid/ready.
// Define LUT_DUMP_LOOP_EN to add the loop_en input for continuously repeating dumps.
module lut_dump_sequencer
    import lut_dump_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 2
) (
    input  logic                  user_clk,
    input  logic                  user_rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [PERIOD_W-1:0]   period,
    input  logic [ADDR_W-1:0]     last_addr,
`ifdef LUT_DUMP_LOOP_EN
    input  logic                  loop_en,
`endif
    output logic [ADDR_W-1:0]     lut_addr,
    output logic                  lut_rd_en,
    input  logic [DATA_W-1:0]     lut_rd_data,
    output logic [DATA_W-1:0]     out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done,
    output logic [LATE_CNT_W-1:0] late_cnt
);

    state_t                state_q;
    logic [PERIOD_W-1:0]   period_q;
    logic [ADDR_W-1:0]     last_q;
    logic [ADDR_W-1:0]     addr_q;
    logic                  loop_q;
    logic                  abort_q;
    logic                  rd_en_q;
    logic [DATA_W-1:0]     data_q;
    logic                  valid_q;
    logic                  olast_q;
    logic                  busy_q;
    logic                  done_q;
    logic [LATE_CNT_W-1:0] late_q;

    logic [PERIOD_W-1:0]   eff;
    logic [PERIOD_W-1:0]   cnt;
    logic                  elapsed;
    logic                  fetch_done;
    logic                  late_hit;
    logic                  stop;

    assign eff        = eff_period(period_q, RD_LAT);
    assign fetch_done = (cnt == PERIOD_W'(RD_LAT - 1));
    assign late_hit   = (cnt == eff - PERIOD_W'(1));
    assign stop       = abort || abort_q || (olast_q && !loop_q);

    lut_dump_interval_ctr u_ctr (
        .clk          (user_clk),
        .rst          (user_rst),
        .restart_i    (state_q == ISSUE),
        .eff_period_i (eff),
        .cnt_o        (cnt),
        .elapsed_o    (elapsed)
    );

    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            state_q  <= IDLE;
            period_q <= '0;
            last_q   <= '0;
            addr_q   <= '0;
            loop_q   <= 1'b0;
            abort_q  <= 1'b0;
            rd_en_q  <= 1'b0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            olast_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            late_q   <= '0;
        end else begin
            rd_en_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    if (start) begin
                        period_q <= period;
                        last_q   <= last_addr;
`ifdef LUT_DUMP_LOOP_EN
                        loop_q   <= loop_en;
`else
                        loop_q   <= 1'b0;
`endif
                        addr_q   <= '0;
                        abort_q  <= 1'b0;
                        late_q   <= '0;
                        busy_q   <= 1'b0 | 1'b1;
                        rd_en_q  <= 1'b1;
                        state_q  <= ISSUE;
                    end
                end
                // The counter reads 0 in ISSUE, so it doubles as the read-latency timer.
                ISSUE, FETCH: begin
                    abort_q <= abort_q | abort;
                    if (fetch_done) begin
                        data_q  <= lut_rd_data;
                        valid_q <= 1'b1;
                        olast_q <= (addr_q == last_q);
                        state_q <= HOLD;
                    end else begin
                        state_q <= FETCH;
                    end
                end
                HOLD: begin
                    abort_q <= abort_q | abort;
                    if (out_ready) begin
                        valid_q <= 1'b0;
                        olast_q <= 1'b0;
                        if (stop) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= DONE;
                        end else begin
                            addr_q <= olast_q ? '0 : addr_q + ADDR_W'(1);
                            // A late or exactly-due read goes out straight after the handshake.
                            if (elapsed) begin
                                rd_en_q <= 1'b1;
                                state_q <= ISSUE;
                            end else begin
                                state_q <= WAIT;
                            end
                        end
                    end else if (late_hit && late_q != '1) begin
                        late_q <= late_q + LATE_CNT_W'(1);
                    end
                end
                WAIT: begin
                    if (abort) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= DONE;
                    end else if (elapsed) begin
                        rd_en_q <= 1'b1;
                        state_q <= ISSUE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign lut_addr  = addr_q;
    assign lut_rd_en = rd_en_q;
    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign out_last  = olast_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign late_cnt  = late_q;

endmodule

// File: tb/tb_lut_dump_sequencer.sv
// Randomized bench for lut_dump_sequencer against a transaction-timing model of the dump.
`timescale 1ns/1ps
module tb_lut_dump_sequencer;
    import lut_dump_pkg::*;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam int RD_LAT = 2;
    localparam int DEPTH  = 1 << ADDR_W;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  start;
    logic                  abort;
    logic [PERIOD_W-1:0]   period;
    logic [ADDR_W-1:0]     last_addr;
`ifdef LUT_DUMP_LOOP_EN
    logic                  loop_en;
`endif
    logic [ADDR_W-1:0]     lut_addr;
    logic                  lut_rd_en;
    logic [DATA_W-1:0]     lut_rd_data;
    logic [DATA_W-1:0]     out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_last;
    logic                  busy;
    logic                  done;
    logic [LATE_CNT_W-1:0] late_cnt;

    always #5 clk = ~clk;

    lut_dump_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
        .user_clk    (clk),
        .user_rst    (rst),
        .start       (start),
        .abort       (abort),
        .period      (period),
        .last_addr   (last_addr),
`ifdef LUT_DUMP_LOOP_EN
        .loop_en     (loop_en),
`endif
        .lut_addr    (lut_addr),
        .lut_rd_en   (lut_rd_en),
        .lut_rd_data (lut_rd_data),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_last    (out_last),
        .busy        (busy),
        .done        (done),
        .late_cnt    (late_cnt)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // LUT: data for a read launched in cycle c is presented only during cycle c+RD_LAT-1.
    logic [DATA_W-1:0] mem [DEPTH];
    int                pend_t = -100;
    logic [DATA_W-1:0] pend_d = '0;
    always @(negedge clk) begin
        if (lut_rd_en) begin
            pend_t = cyc + RD_LAT - 1;
            pend_d = mem[lut_addr];
        end
    end
    assign lut_rd_data = (cyc == pend_t) ? pend_d : ~pend_d;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model state
    bit active, inflight, abort_p, m_loop;
    int issue_t, next_issue, done_t, cur_addr, m_last, m_eff, nwords, m_late;

    task automatic run_dump(input int per, input int last, input int ready_pct,
                            input int stall_word, input int abort_mode, input int abort_word,
                            input bit lp, input int exp_words);
        int  s_cyc;
        int  guard;
        bit  rdy, ab, fired, e_rd, e_vld, e_busy, e_done;
        @(posedge clk); #1;
        start = 1'b1; abort = 1'b0; out_ready = 1'b1;
        period = PERIOD_W'(per); last_addr = ADDR_W'(last);
`ifdef LUT_DUMP_LOOP_EN
        loop_en = lp;
`endif
        @(negedge clk);
        check("idle_busy", busy, 0);
        s_cyc = cyc;
        active = 1; inflight = 0; abort_p = 0; fired = 0;
        next_issue = cyc + 1; done_t = -1; cur_addr = 0; nwords = 0; m_late = 0;
        m_last = last; m_loop = lp;
        m_eff = (per > RD_LAT + 1) ? per : RD_LAT + 1;
        for (guard = 0; guard < 20000; guard++) begin
            @(posedge clk); #1;
            start     = active && ($urandom_range(0, 19) == 0);
            period    = $urandom;
            last_addr = ADDR_W'($urandom);
            rdy = ($urandom_range(1, 100) <= ready_pct);
            if (inflight && nwords == stall_word && cyc < issue_t + RD_LAT + 10) rdy = 0;
            out_ready = rdy;
            ab = 0;
            case (abort_mode)
                1: ab = active && !fired && !inflight && cyc != next_issue && nwords == abort_word + 1;
                2: ab = active && !fired && inflight && nwords == abort_word && cyc >= issue_t + RD_LAT;
                3: ab = active && ($urandom_range(0, 29) == 0);
                default: ab = 0;
            endcase
            if (ab) fired = 1;
            abort = ab;
            @(negedge clk);
            e_rd = active && cyc == next_issue;
            if (e_rd) begin
                inflight = 1;
                issue_t  = cyc;
            end
            e_vld  = active && inflight && cyc >= issue_t + RD_LAT;
            e_busy = active;
            e_done = !active && cyc == done_t;
            check("rd_en", lut_rd_en, e_rd);
            if (e_rd) check("rd_addr", lut_addr, cur_addr);
            check("out_valid", out_valid, e_vld);
            check("busy", busy, e_busy);
            check("done", done, e_done);
            if (cyc == s_cyc + 1) check("late_clr", late_cnt, 0);
            if (e_done) check("late_cnt", late_cnt, m_late);
            if (active) begin
                if (ab) abort_p = 1;
                if (e_vld) begin
                    check("out_data", out_data, mem[cur_addr]);
                    check("out_last", out_last, cur_addr == m_last);
                end
                if (e_vld && rdy) begin
                    nwords++;
                    if (cyc > issue_t + m_eff - 1 && m_late < 65535) m_late++;
                    inflight = 0;
                    if (abort_p || (cur_addr == m_last && !m_loop)) begin
                        active = 0;
                        done_t = cyc + 1;
                    end else begin
                        cur_addr   = (cur_addr == m_last) ? 0 : cur_addr + 1;
                        next_issue = (issue_t + m_eff > cyc + 1) ? issue_t + m_eff : cyc + 1;
                    end
                end else if (!inflight && ab) begin
                    active = 0;
                    done_t = cyc + 1;
                end
            end
            if (!active && cyc == done_t) break;
        end
        start = 1'b0; abort = 1'b0;
        check("dump_end", active, 0);
        if (exp_words >= 0) check("word_count", nwords, exp_words);
    endtask

    task automatic reset_mid_fetch();
        @(posedge clk); #1;
        start = 1'b1; period = 4; last_addr = 3; out_ready = 1'b1; abort = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_rd_en", lut_rd_en, 0);
        check("rst_addr", lut_addr, 0);
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_last", out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_late", late_cnt, 0);
        check("rst_done", done, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst_no_done", done, 0);
            check("rst_idle_rd", lut_rd_en, 0);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
        period = '0; last_addr = '0;
`ifdef LUT_DUMP_LOOP_EN
        loop_en = 1'b0;
`endif
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_valid", out_valid, 0);
        check("reset_rd_en", lut_rd_en, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_late", late_cnt, 0);
        check("reset_data", out_data, 0);

        run_dump(4, 3, 100, -1, 0, 0, 0, 4);
        run_dump(0, 2, 100, -1, 0, 0, 0, 3);
        run_dump(4, 3, 100, 1, 0, 0, 0, 4);
        run_dump(4, 3, 100, -1, 1, 1, 0, 2);
        run_dump(4, 3, 100, 1, 2, 1, 0, 2);
        reset_mid_fetch();
        run_dump(3, 0, 100, -1, 0, 0, 0, 1);
        run_dump(0, DEPTH - 1, 100, -1, 0, 0, 0, DEPTH);
`ifdef LUT_DUMP_LOOP_EN
        run_dump(2, 1, 100, -1, 2, 5, 1, 6);
        run_dump(5, 2, 70, -1, 1, 4, 1, 5);
`endif
        for (int k = 0; k < 25; k++) begin
            run_dump($urandom_range(0, 7), $urandom_range(0, 6), $urandom_range(40, 100), -1,
                     ($urandom_range(0, 3) == 0) ? 3 : 0, 0, 0, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
